// File: rtl/stage4_vreg_scoreboard_pkg.sv
// ============================================================================
// Module      : stage4_vreg_scoreboard_pkg
// Description : Shared types and constants for the stage-4 vector-register scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage4_vreg_scoreboard_pkg;

    localparam int VSB_DEPTH = 4;
    localparam int VSB_NREG  = 32;
    localparam int VSB_PTR_W = $clog2(VSB_DEPTH) + 1;

    typedef logic [4:0] regsel_t;

    typedef struct packed {
        regsel_t vd;
        logic    vd_used;
    } vsb_entry_t;

endpackage

`default_nettype wire

// File: rtl/stage4_vreg_scoreboard.sv
// ============================================================================
// Module      : stage4_vreg_scoreboard
// Description : In-order vector-register scoreboard (head/commit/tail ring) that
//               stalls issue on RAW/WAW/v0-mask hazards. Optional macro
//               VSB_BYPASS_EN lets a uop issue in its producer's retire cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage4_vreg_scoreboard
    import stage4_vreg_scoreboard_pkg::*;
#(
    parameter int DEPTH = VSB_DEPTH,
    parameter int NREG  = VSB_NREG
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            issue_req_i,
    input  regsel_t         vs1_i,
    input  regsel_t         vs2_i,
    input  regsel_t         vd_i,
    input  logic            vs1_used_i,
    input  logic            vs2_used_i,
    input  logic            vd_used_i,
    input  logic            mask_dep_i,
    input  logic            issue_fire_i,
    input  logic            mem_enter_i,
    input  logic            retire_i,
    input  logic            flush_i,
    output logic            vstall_o,
    output logic            sb_full_o,
    output logic            sb_empty_o,
    output logic [NREG-1:0] pend_mask_o
);

    localparam int PTR_W = $clog2(DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;

    logic [PTR_W-1:0] head_q, commit_q, tail_q;
    logic [PTR_W-1:0] head_d, commit_d, tail_d;
    logic [PTR_W-1:0] w_occ;
    vsb_entry_t       entries_q [DEPTH];

    logic             w_full, w_empty, w_pop, w_commit, w_push;
    logic             w_full_chk, w_hazard;
    logic [NREG-1:0]  w_ent_mask [DEPTH];
    logic [NREG-1:0]  w_ent_chk  [DEPTH];
    logic [NREG-1:0]  w_pend, w_pend_chk;

    assign w_occ   = tail_q - head_q;
    assign w_empty = (head_q == tail_q);
    assign w_full  = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                     (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);

    // Protocol-violating mem_enter/retire requests are silently dropped here.
    assign w_pop    = retire_i & (head_q != commit_q);
    assign w_commit = mem_enter_i & (commit_q != tail_q);
    assign w_push   = issue_fire_i & ~flush_i & (~w_full | w_pop);

    always_comb begin
        head_d   = head_q + PTR_W'(w_pop);
        commit_d = commit_q + PTR_W'(w_commit);
        tail_d   = flush_i ? commit_d : tail_q + PTR_W'(w_push);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q   <= '0;
            commit_q <= '0;
            tail_q   <= '0;
        end else begin
            head_q   <= head_d;
            commit_q <= commit_d;
            tail_q   <= tail_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            entries_q[tail_q[IDX_W-1:0]] <= '{vd: vd_i, vd_used: vd_used_i};
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        logic [IDX_W-1:0] w_off;
        logic             w_valid;
        assign w_off      = IDX_W'(i) - head_q[IDX_W-1:0];
        assign w_valid    = ({1'b0, w_off} < w_occ);
        assign w_ent_mask[i] = (w_valid & entries_q[i].vd_used) ?
                               (NREG'(1) << entries_q[i].vd) : '0;
`ifdef VSB_BYPASS_EN
        // The retiring head writes back this cycle, so it no longer blocks readers.
        assign w_ent_chk[i] = (w_pop && (head_q[IDX_W-1:0] == IDX_W'(i))) ?
                              '0 : w_ent_mask[i];
`else
        assign w_ent_chk[i] = w_ent_mask[i];
`endif
    end

    always_comb begin
        w_pend     = '0;
        w_pend_chk = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_pend     = w_pend | w_ent_mask[i];
            w_pend_chk = w_pend_chk | w_ent_chk[i];
        end
    end

`ifdef VSB_BYPASS_EN
    assign w_full_chk = w_full & ~w_pop;
`else
    assign w_full_chk = w_full;
`endif

    assign w_hazard = (vs1_used_i & w_pend_chk[vs1_i]) |
                      (vs2_used_i & w_pend_chk[vs2_i]) |
                      (vd_used_i  & w_pend_chk[vd_i])  |
                      (mask_dep_i & w_pend_chk[0]);

    assign vstall_o    = issue_req_i & (w_hazard | w_full_chk);
    assign sb_full_o   = w_full;
    assign sb_empty_o  = w_empty;
    assign pend_mask_o = w_pend;

    a_commit_ok: assert property (@(posedge clk_i) disable iff (rst_i)
        mem_enter_i |-> (commit_q != tail_q));
    a_retire_ok: assert property (@(posedge clk_i) disable iff (rst_i)
        retire_i |-> (head_q != commit_q));

endmodule

`default_nettype wire

// File: tb/tb_stage4_vreg_scoreboard.sv
// ============================================================================
// Module      : tb_stage4_vreg_scoreboard
// Description : Directed self-checking bench for stage4_vreg_scoreboard
//               (expectations follow VSB_BYPASS_EN when it is defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage4_vreg_scoreboard;
    import stage4_vreg_scoreboard_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_req, vs1_used, vs2_used, vd_used, mask_dep;
    logic        issue_fire, mem_enter, retire, flush;
    regsel_t     vs1, vs2, vd;
    logic        vstall, sb_full, sb_empty;
    logic [31:0] pend_mask;

    int n_cmp = 0;
    int n_bad = 0;

    stage4_vreg_scoreboard #(.DEPTH(4), .NREG(32)) dut (
        .clk_i(clk), .rst_i(rst), .issue_req_i(issue_req),
        .vs1_i(vs1), .vs2_i(vs2), .vd_i(vd),
        .vs1_used_i(vs1_used), .vs2_used_i(vs2_used), .vd_used_i(vd_used),
        .mask_dep_i(mask_dep), .issue_fire_i(issue_fire), .mem_enter_i(mem_enter),
        .retire_i(retire), .flush_i(flush), .vstall_o(vstall),
        .sb_full_o(sb_full), .sb_empty_o(sb_empty), .pend_mask_o(pend_mask)
    );

    always #5 clk = ~clk;

    task automatic idle();
        issue_req = 0; vs1_used = 0; vs2_used = 0; vd_used = 0; mask_dep = 0;
        issue_fire = 0; mem_enter = 0; retire = 0; flush = 0;
        vs1 = '0; vs2 = '0; vd = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int r);
        issue_req = 1; vd = regsel_t'(r); vd_used = 1; issue_fire = 1;
        tick();
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_empty", 32'(sb_empty), 32'd1);
        chk("rst_full", 32'(sb_full), 32'd0);
        chk("rst_pend", pend_mask, 32'h0);
        chk("rst_vstall", 32'(vstall), 32'd0);

        // 1: basic issue
        issue_req = 1; vs1 = 3; vs1_used = 1; #1;
        chk("t1_nohaz", 32'(vstall), 32'd0);
        vd = 5; vd_used = 1; issue_fire = 1;
        tick();
        chk("t1_pend", pend_mask, 32'h20);
        chk("t1_empty", 32'(sb_empty), 32'd0);

        // 2: RAW on v5
        issue_req = 1; vs2 = 5; vs2_used = 1; #1;
        chk("t2_raw", 32'(vstall), 32'd1);
        mem_enter = 1;
        tick();
        issue_req = 1; vs2 = 5; vs2_used = 1; #1;
        chk("t2_raw_mem", 32'(vstall), 32'd1);
        retire = 1; #1;
`ifdef VSB_BYPASS_EN
        chk("t2_retire_cyc", 32'(vstall), 32'd0);
`else
        chk("t2_retire_cyc", 32'(vstall), 32'd1);
`endif
        tick();
        issue_req = 1; vs2 = 5; vs2_used = 1; #1;
        chk("t2_after", 32'(vstall), 32'd0);
        chk("t2_empty", 32'(sb_empty), 32'd1);

        // 3: v0 mask dependency
        idle();
        push(0);
        chk("t3_pend", pend_mask, 32'h1);
        issue_req = 1; vs1 = 7; vs2 = 8; vs1_used = 1; vs2_used = 1; mask_dep = 1; #1;
        chk("t3_mask", 32'(vstall), 32'd1);
        mask_dep = 0; #1;
        chk("t3_nomask", 32'(vstall), 32'd0);
        idle(); mem_enter = 1; tick();
        retire = 1; tick();
        chk("t3_empty", 32'(sb_empty), 32'd1);

        // 4: fill to full
        push(1); push(2); push(3); push(4);
        chk("t4_full", 32'(sb_full), 32'd1);
        chk("t4_pend", pend_mask, 32'h1E);
        issue_req = 1; vs1 = 9; vs1_used = 1; #1;
        chk("t4_full_stall", 32'(vstall), 32'd1);
        idle(); mem_enter = 1; tick();
        issue_req = 1; vd = 7; vd_used = 1; retire = 1; #1;
`ifdef VSB_BYPASS_EN
        chk("t4_swap_stall", 32'(vstall), 32'd0);
`else
        chk("t4_swap_stall", 32'(vstall), 32'd1);
`endif
        issue_fire = 1;
        tick();
        chk("t4_swap_full", 32'(sb_full), 32'd1);
        chk("t4_swap_pend", pend_mask, 32'h9C);
        for (int i = 0; i < 4; i++) begin mem_enter = 1; tick(); end
        for (int i = 0; i < 4; i++) begin retire = 1; tick(); end
        chk("t4_drained", 32'(sb_empty), 32'd1);

        // 5: flush
        push(10); push(11); push(12);
        mem_enter = 1; tick();
        chk("t5_pre", pend_mask, 32'h1C00);
        flush = 1; tick();
        chk("t5_flush", pend_mask, 32'h0400);
        chk("t5_nonempty", 32'(sb_empty), 32'd0);
        push(11); push(12);
        issue_req = 1; vd = 13; vd_used = 1; issue_fire = 1; flush = 1; mem_enter = 1;
        tick();
        chk("t5_flush_mem", pend_mask, 32'h0C00);
        push(12);
        chk("t5_repush", pend_mask, 32'h1C00);

        // 6: reset with entries in flight
        rst = 1; tick(); rst = 0; #1;
        chk("t6_empty", 32'(sb_empty), 32'd1);
        chk("t6_pend", pend_mask, 32'h0);
        issue_req = 1; vs1 = 12; vs1_used = 1; vd = 11; vd_used = 1; mask_dep = 1; #1;
        chk("t6_vstall", 32'(vstall), 32'd0);
        chk("t6_full", 32'(sb_full), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
